// File: rtl/pl_stage_skid.sv
// Pipeline stage with an optional skid entry: a main entry drives the outputs and,
// when SKID=1, a second entry absorbs the input so in_ready never depends on out_ready.
module pl_stage_skid #(
   parameter int DATA_W = 96,
   parameter int CTRL_W = 16,
   parameter int SKID   = 1
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   input  logic              hold,
   input  logic              flush,
   output logic [1:0]        occupancy
);

   logic              main_valid_reg, main_valid_next;
   logic [CTRL_W-1:0] main_ctrl_reg,  main_ctrl_next;
   logic [DATA_W-1:0] main_data_reg,  main_data_next;
   logic              skid_valid_reg, skid_valid_next;
   logic [CTRL_W-1:0] skid_ctrl_reg,  skid_ctrl_next;
   logic [DATA_W-1:0] skid_data_reg,  skid_data_next;
   logic [1:0]        occupancy_reg,  occupancy_next;
   logic              accept;
   logic              drain;

   // With a skid entry, readiness only looks at local state, breaking the ready path.
   assign in_ready  = ((SKID != 0) ? !skid_valid_reg : (!main_valid_reg || out_ready))
                      && !hold && !flush;
   assign accept    = in_valid && in_ready;
   assign drain     = main_valid_reg && out_ready && !hold;

   assign out_valid = main_valid_reg;
   assign out_ctrl  = main_valid_reg ? main_ctrl_reg : '0;
   assign out_data  = main_data_reg;
   assign occupancy = occupancy_reg;

   always_comb begin
      main_valid_next = main_valid_reg;
      main_ctrl_next  = main_ctrl_reg;
      main_data_next  = main_data_reg;
      skid_valid_next = skid_valid_reg;
      skid_ctrl_next  = skid_ctrl_reg;
      skid_data_next  = skid_data_reg;
      if (flush) begin
         main_valid_next = 1'b0;
         main_ctrl_next  = '0;
         skid_valid_next = 1'b0;
         skid_ctrl_next  = '0;
      end else if (!hold) begin
         if (skid_valid_reg) begin
            // in_ready is low here, so only the skid-to-main move can happen.
            if (drain) begin
               main_valid_next = 1'b1;
               main_ctrl_next  = skid_ctrl_reg;
               main_data_next  = skid_data_reg;
               skid_valid_next = 1'b0;
               skid_ctrl_next  = '0;
            end
         end else if (!main_valid_reg || drain) begin
            if (accept) begin
               main_valid_next = 1'b1;
               main_ctrl_next  = in_ctrl;
               main_data_next  = in_data;
            end else if (drain) begin
               main_valid_next = 1'b0;
               main_ctrl_next  = '0;
            end
         end else if (accept && (SKID != 0)) begin
            skid_valid_next = 1'b1;
            skid_ctrl_next  = in_ctrl;
            skid_data_next  = in_data;
         end
      end
      occupancy_next = {1'b0, main_valid_next} + {1'b0, skid_valid_next};
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         main_valid_reg <= 1'b0;
         main_ctrl_reg  <= '0;
         main_data_reg  <= '0;
         skid_valid_reg <= 1'b0;
         skid_ctrl_reg  <= '0;
         skid_data_reg  <= '0;
         occupancy_reg  <= 2'd0;
      end else begin
         main_valid_reg <= main_valid_next;
         main_ctrl_reg  <= main_ctrl_next;
         main_data_reg  <= main_data_next;
         skid_valid_reg <= skid_valid_next;
         skid_ctrl_reg  <= skid_ctrl_next;
         skid_data_reg  <= skid_data_next;
         occupancy_reg  <= occupancy_next;
      end
   end

endmodule

// File: tb/tb_pl_stage_skid.sv
// Bench for pl_stage_skid: a SKID=1 and a SKID=0 instance share stimulus and are each
// compared against a queue model holding the entries in acceptance order.
module tb_pl_stage_skid;

   localparam int DW = 96;
   localparam int CW = 16;
   typedef logic [CW+DW-1:0] ent_t;

   logic          CLK;
   logic          nRST;
   logic          in_valid;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;
   logic          out_ready;
   logic          hold;
   logic          flush;

   logic          in_ready1, out_valid1, in_ready0, out_valid0;
   logic [CW-1:0] out_ctrl1, out_ctrl0;
   logic [DW-1:0] out_data1, out_data0;
   logic [1:0]    occ1, occ0;

   ent_t q1[$];
   ent_t q0[$];
   int   vectors;
   int   miscompares;

   pl_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut (
      .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready1),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
      .out_ctrl(out_ctrl1), .out_data(out_data1), .hold(hold), .flush(flush),
      .occupancy(occ1));

   pl_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
      .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready0),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
      .out_ctrl(out_ctrl0), .out_data(out_data0), .hold(hold), .flush(flush),
      .occupancy(occ0));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Expected readiness straight from the capacity rules of each variant.
   function automatic logic exp_rdy1();
      return (q1.size() < 2) && !hold && !flush;
   endfunction
   function automatic logic exp_rdy0();
      return ((q0.size() == 0) || out_ready) && !hold && !flush;
   endfunction

   task automatic set_in(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic ordy, input logic h, input logic f);
      in_valid = v; in_ctrl = c; in_data = d; out_ready = ordy; hold = h; flush = f;
      #1;
   endtask

   // Advance one clock and update both queue models with the same inputs.
   task automatic tick();
      logic acc1, dr1, acc0, dr0;
      acc1 = in_valid && exp_rdy1();
      dr1  = (q1.size() > 0) && out_ready && !hold;
      acc0 = in_valid && exp_rdy0();
      dr0  = (q0.size() > 0) && out_ready && !hold;
      @(posedge CLK);
      if (flush) begin
         q1.delete();
         q0.delete();
      end else if (!hold) begin
         if (dr1) void'(q1.pop_front());
         if (acc1) q1.push_back({in_ctrl, in_data});
         if (dr0) void'(q0.pop_front());
         if (acc0) q0.push_back({in_ctrl, in_data});
      end
      @(negedge CLK);
      #1;
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      #2;
      vectors++;
      if (out_valid1 !== 1'b0 || occ1 !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_valid_occ: got valid=%0b occ=%0d expected 0/0", out_valid1, occ1);
      end
      vectors++;
      if (out_ctrl1 !== '0 || out_data1 !== '0 || out_data0 !== '0) begin
         miscompares++;
         $display("FAIL reset_payload: got ctrl=%0h data=%0h data0=%0h expected 0", out_ctrl1, out_data1, out_data0);
      end
      @(negedge CLK);
      nRST = 1'b1;
      #1;
      vectors++;
      if (in_ready1 !== 1'b1 || in_ready0 !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_in_ready: got %0b/%0b expected 1/1", in_ready1, in_ready0);
      end
   endtask

   task automatic test_single();
      set_in(1'b1, 16'h0005, 96'hA, 1'b1, 1'b0, 1'b0);
      tick();
      set_in(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (out_valid1 !== 1'b1 || out_ctrl1 !== 16'h0005 || out_data1 !== 96'hA) begin
         miscompares++;
         $display("FAIL single_out: got v=%0b c=%0h d=%0h expected 1/5/a", out_valid1, out_ctrl1, out_data1);
      end
      tick();
      vectors++;
      if (occ1 !== 2'd0 || out_valid1 !== 1'b0 || out_ctrl1 !== '0) begin
         miscompares++;
         $display("FAIL single_drained: got occ=%0d v=%0b c=%0h expected 0/0/0", occ1, out_valid1, out_ctrl1);
      end
   endtask

   task automatic test_fill_drain();
      ent_t a, b;
      a = {16'h00A1, 96'h1111_2222_3333};
      b = {16'h00B2, 96'h4444_5555_6666};
      set_in(1'b1, a[CW+DW-1:DW], a[DW-1:0], 1'b0, 1'b0, 1'b0);
      tick();
      set_in(1'b1, b[CW+DW-1:DW], b[DW-1:0], 1'b0, 1'b0, 1'b0);
      tick();
      set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (occ1 !== 2'd2 || in_ready1 !== 1'b0) begin
         miscompares++;
         $display("FAIL fill_full: got occ=%0d rdy=%0b expected 2/0", occ1, in_ready1);
      end
      set_in(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if ({out_ctrl1, out_data1} !== a || out_valid1 !== 1'b1) begin
         miscompares++;
         $display("FAIL drain_first: got %0h expected %0h", {out_ctrl1, out_data1}, a);
      end
      tick();
      vectors++;
      if ({out_ctrl1, out_data1} !== b || out_valid1 !== 1'b1) begin
         miscompares++;
         $display("FAIL drain_second: got %0h expected %0h", {out_ctrl1, out_data1}, b);
      end
      tick();
      vectors++;
      if (out_valid1 !== 1'b0 || occ1 !== 2'd0) begin
         miscompares++;
         $display("FAIL drain_empty: got v=%0b occ=%0d expected 0/0", out_valid1, occ1);
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 2; i++) begin
         set_in(1'b1, 16'h0100 + 16'(i), 96'(i + 7), 1'b0, 1'b0, 1'b0);
         tick();
      end
      set_in(1'b1, 16'hFFFF, 96'h5, 1'b1, 1'b1, 1'b1);
      vectors++;
      if (occ1 !== 2'd2 || in_ready1 !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_pre: got occ=%0d rdy=%0b expected 2/0", occ1, in_ready1);
      end
      tick();
      set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (occ1 !== 2'd0 || out_valid1 !== 1'b0 || out_ctrl1 !== '0 || occ0 !== 2'd0) begin
         miscompares++;
         $display("FAIL flush_post: got occ=%0d v=%0b c=%0h occ0=%0d expected 0/0/0/0", occ1, out_valid1, out_ctrl1, occ0);
      end
   endtask

   task automatic test_hold();
      logic [CW-1:0] c0;
      logic [DW-1:0] d0;
      set_in(1'b1, 16'h0042, 96'hBEEF, 1'b0, 1'b0, 1'b0);
      tick();
      c0 = out_ctrl1;
      d0 = out_data1;
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 16'h0077, 96'hCAFE, 1'b1, 1'b1, 1'b0);
         vectors++;
         if (in_ready1 !== 1'b0 || in_ready0 !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_ready%0d: got %0b/%0b expected 0/0", i, in_ready1, in_ready0);
         end
         tick();
         vectors++;
         if (out_valid1 !== 1'b1 || out_ctrl1 !== 16'h0042 || out_data1 !== 96'hBEEF || occ1 !== 2'd1) begin
            miscompares++;
            $display("FAIL hold_state%0d: got v=%0b c=%0h d=%0h occ=%0d expected 1/42/beef/1", i, out_valid1, out_ctrl1, out_data1, occ1);
         end
      end
      if (c0 !== 16'h0042 || d0 !== 96'hBEEF) $display("note: pre-hold entry %0h/%0h", c0, d0);
      set_in(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      tick();
   endtask

   task automatic test_skid0_throughput();
      set_in(1'b1, 16'h0300, 96'h300, 1'b0, 1'b0, 1'b0);
      tick();
      for (int i = 1; i <= 5; i++) begin
         set_in(1'b1, 16'h0300 + 16'(i), 96'h300 + 96'(i), 1'b1, 1'b0, 1'b0);
         vectors++;
         if (in_ready0 !== 1'b1 || occ0 !== 2'd1 || out_ctrl0 !== 16'h0300 + 16'(i - 1)) begin
            miscompares++;
            $display("FAIL skid0_b2b%0d: got rdy=%0b occ=%0d c=%0h expected 1/1/%0h", i, in_ready0, occ0, out_ctrl0, 16'h0300 + 16'(i - 1));
         end
         tick();
      end
      set_in(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
   endtask

   task automatic test_random();
      ent_t e;
      for (int n = 0; n < 400; n++) begin
         set_in($urandom_range(0, 9) < 7, CW'($urandom), {$urandom, $urandom, $urandom},
                $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
         vectors++;
         if (in_ready1 !== exp_rdy1() || in_ready0 !== exp_rdy0()) begin
            miscompares++;
            $display("FAIL rand_ready@%0d: got %0b/%0b expected %0b/%0b", n, in_ready1, in_ready0, exp_rdy1(), exp_rdy0());
         end
         tick();
         vectors++;
         if (out_valid1 !== (q1.size() > 0) || occ1 !== 2'(q1.size()) ||
             out_valid0 !== (q0.size() > 0) || occ0 !== 2'(q0.size())) begin
            miscompares++;
            $display("FAIL rand_occ@%0d: got v=%0b/%0b occ=%0d/%0d expected occ %0d/%0d", n, out_valid1, out_valid0, occ1, occ0, q1.size(), q0.size());
         end
         e = (q1.size() > 0) ? q1[0] : '0;
         vectors++;
         if (out_ctrl1 !== e[CW+DW-1:DW] || (q1.size() > 0 && out_data1 !== e[DW-1:0])) begin
            miscompares++;
            $display("FAIL rand_out1@%0d: got %0h/%0h expected %0h", n, out_ctrl1, out_data1, e);
         end
         e = (q0.size() > 0) ? q0[0] : '0;
         vectors++;
         if (out_ctrl0 !== e[CW+DW-1:DW] || (q0.size() > 0 && out_data0 !== e[DW-1:0])) begin
            miscompares++;
            $display("FAIL rand_out0@%0d: got %0h/%0h expected %0h", n, out_ctrl0, out_data0, e);
         end
      end
   endtask

   task automatic test_async_reset();
      set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      tick();
      for (int i = 0; i < 2; i++) begin
         set_in(1'b1, 16'h0900 + 16'(i), 96'h900 + 96'(i), 1'b0, 1'b0, 1'b0);
         tick();
      end
      set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (occ1 !== 2'd2) begin
         miscompares++;
         $display("FAIL areset_pre: got occ=%0d expected 2", occ1);
      end
      nRST = 1'b0;
      #1;
      q1.delete();
      q0.delete();
      vectors++;
      if (out_valid1 !== 1'b0 || occ1 !== 2'd0 || out_ctrl1 !== '0 || out_data1 !== '0 || out_valid0 !== 1'b0) begin
         miscompares++;
         $display("FAIL areset_now: got v=%0b occ=%0d c=%0h d=%0h v0=%0b expected all 0", out_valid1, occ1, out_ctrl1, out_data1, out_valid0);
      end
      @(negedge CLK);
      nRST = 1'b1;
      #1;
      set_in(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      tick();
      vectors++;
      if (out_valid1 !== 1'b0 || occ1 !== 2'd0 || in_ready1 !== 1'b1) begin
         miscompares++;
         $display("FAIL areset_after: got v=%0b occ=%0d rdy=%0b expected 0/0/1", out_valid1, occ1, in_ready1);
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_single();
      test_fill_drain();
      test_flush();
      test_hold();
      test_skid0_throughput();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pl_stage_skid.md
PL_STAGE_SKID -- requirements
Module: pl_stage_skid

Interface
REQ-001 SHALL provide parameter DATA_W, default 96: width of the stage payload (operands, immediates, addresses).
REQ-002 SHALL provide parameter CTRL_W, default 16: width of the control field, forced to zero in bubbles.
REQ-003 SHALL provide parameter SKID, default 1: 1 = two-entry skid stage, 0 = single-entry stage.
REQ-004 SHALL have port CLK  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port nRST  input  1  reset; asynchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  upstream presents an entry.
REQ-007 SHALL have port in_ready  output  1  stage accepts the upstream entry this cycle.
REQ-008 SHALL have port in_ctrl  input  CTRL_W  upstream control bits.
REQ-009 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-010 SHALL have port out_valid  output  1  stage presents an entry downstream.
REQ-011 SHALL have port out_ready  input  1  downstream consumes the entry this cycle.
REQ-012 SHALL have port out_ctrl  output  CTRL_W  downstream control bits.
REQ-013 SHALL have port out_data  output  DATA_W  downstream payload.
REQ-014 SHALL have port hold  input  1  freeze: no accept, no drain, state unchanged.
REQ-015 SHALL have port flush  input  1  discard all held entries.
REQ-016 SHALL have port occupancy  output  2  number of valid entries held (0..2).

Function
REQ-017 SHALL hold a main entry (drives outputs) and, when SKID=1, a skid entry, each with a valid bit, ctrl and data.
REQ-018 SHALL drive out_valid = main valid; out_ctrl = main ctrl when valid, else all zeros; out_data = main data unconditionally.
REQ-019 SHALL define accept = in_valid & in_ready and drain = out_valid & out_ready & !hold.
REQ-020 SHALL drive in_ready = !skid_valid & !hold & !flush when SKID=1, so in_ready depends on no downstream input.
REQ-021 SHALL drive in_ready = (!main_valid | out_ready) & !hold & !flush when SKID=0.
REQ-022 SHALL, when hold=1 and flush=0, leave all state unchanged.
REQ-023 SHALL, when flush=1, clear both valid bits and zero both ctrl fields at the next edge, overriding hold, accept and drain.
REQ-024 SHALL treat a transfer with out_valid=1 and out_ready=1 on a flush cycle as completed downstream, with that entry also cleared.
REQ-025 SHALL, on accept with the main entry empty, load main at the next edge, giving out_valid one cycle after accept.
REQ-026 SHALL, on accept with main full and drain, load main from the input.
REQ-027 SHALL, on accept with main full and no drain (SKID=1 only), load the skid entry.
REQ-028 SHALL, on drain with the skid entry valid, move skid into main and clear skid, with no accept possible that cycle.
REQ-029 SHALL, on drain with no accept and the skid entry empty, clear main valid and zero main ctrl.
REQ-030 SHALL deliver entries strictly in acceptance order, with none dropped or duplicated except by flush.
REQ-031 SHALL drive occupancy = main_valid + skid_valid, registered; occupancy never exceeds 1 when SKID=0.

Reset
REQ-032 SHALL, while nRST=0, asynchronously clear both valid bits and all ctrl and data registers to zero.
REQ-033 SHALL therefore present out_valid=0, out_ctrl=0, out_data=0 and occupancy=0 during reset.
REQ-034 SHALL present in_ready=1 after reset when hold=0 and flush=0.
REQ-035 SHALL discard entries in flight when reset asserts mid-operation, with no partial state retained.

Verification
REQ-036 SHALL cover this case: SKID=1, single accept of ctrl=0x0005, data=0xA, out_ready=1 -> out_valid=1 next cycle with 0x0005/0xA, then occupancy=0.
REQ-037 SHALL cover this case: SKID=1, out_ready=0, accept A then B -> occupancy=2, in_ready=0; out_ready=1 then yields A, then B on consecutive cycles.
REQ-038 SHALL cover this case: occupancy=2, flush=1 with in_valid=1 and hold=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, in_ready was 0.
REQ-039 SHALL cover this case: hold=1 for 3 cycles with out_ready=1 and in_valid=1 -> outputs and occupancy unchanged, in_ready=0 throughout.
REQ-040 SHALL cover this case: SKID=0, full, out_ready=1, in_valid=1 -> in_ready=1 and back-to-back throughput of one entry per cycle.
REQ-041 SHALL cover this case: nRST pulsed low mid-stream at occupancy=2 -> immediate out_valid=0 and occupancy=0, with no clock edge required.
